// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair: the receive FSM
// states and the default word width used on both sides of the serial link.
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SERDES_W = 4;

endpackage : serdes_pkg

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: assembles LSB-first words framed by a
// start marker and offers them through a single-entry valid/ready register.
module sipo_deser
    import serdes_pkg::*;
#(
    parameter int WIDTH = SERDES_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sin_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    // Only the WIDTH-1 earlier bits need storing; the final bit joins them
    // straight from sin when the word completes.
    logic [WIDTH-2:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             dout_valid_nxt;
    logic             overrun_nxt;
    logic             frame_err_nxt;

    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             ovr_set;
    logic             frm_set;

    assign word = {sin, sreg};

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sreg_nxt       = sreg;
        dout_nxt       = dout;
        dout_valid_nxt = dout_valid;
        word_done      = 1'b0;
        ovr_set        = 1'b0;
        frm_set        = 1'b0;

        unique case (state)
            IDLE: begin
                if (sin_en && sin_start) begin
                    sreg_nxt           = '0;
                    sreg_nxt[WIDTH-2]  = sin;
                    cnt_nxt            = CNT_W'(1);
                    state_nxt          = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_en && sin_start) begin
                    sreg_nxt           = '0;
                    sreg_nxt[WIDTH-2]  = sin;
                    cnt_nxt            = CNT_W'(1);
                    frm_set            = 1'b1;
                end else if (sin_en) begin
                    sreg_nxt = word[WIDTH-1:1];
                    if (cnt == LAST_BIT) begin
                        word_done = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A completing word may replace one being consumed on the same edge.
        if (word_done) begin
            if (!dout_valid || dout_ready) begin
                dout_nxt       = word;
                dout_valid_nxt = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid_nxt = 1'b0;
        end

        overrun_nxt   = ovr_set | (overrun & ~err_clr);
        frame_err_nxt = frm_set | (frame_err & ~err_clr);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sreg       <= sreg_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            overrun    <= overrun_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

endmodule : sipo_deser

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: stimulus pushes expected words, a monitor
// pops and compares them on every output handshake.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       sin_start = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       overrun;
    logic       frame_err;
    logic       err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    sipo_deser #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .sin_start  (sin_start),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs change just after posedge, so the negedge view is what
    // the next rising edge will see.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {28'h0, dout}, 32'hFFFF_FFFF);
            end else begin
                check("word", {28'h0, dout}, {28'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        sin       = b;
        sin_start = st;
        sin_en    = 1'b1;
        tick();
        sin_en    = 1'b0;
        sin_start = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w, input logic gap);
        for (int i = 0; i < 4; i++) begin
            send_bit(w[i], i == 0);
            if (gap) tick();
        end
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);

        // Single word 0,1,0,1 -> A, valid for exactly one cycle
        dout_ready = 1'b1;
        exp_q.push_back(4'hA);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("single_valid_early", dout_valid, 0);
        send_bit(1'b1, 1'b0);
        check("single_valid_rise", dout_valid, 1);
        check("single_dout", dout, 4'hA);
        tick();
        check("single_valid_fall", dout_valid, 0);

        // Back-to-back words with sin_en toggling
        exp_q.push_back(4'h3);
        exp_q.push_back(4'hC);
        send_word(4'h3, 1'b1);
        send_word(4'hC, 1'b1);
        tick();
        check("b2b_overrun", overrun, 0);
        check("b2b_frame_err", frame_err, 0);

        // Overrun: 9 dropped while 5 is pending
        dout_ready = 1'b0;
        exp_q.push_back(4'h5);
        send_word(4'h5, 1'b0);
        send_word(4'h9, 1'b0);
        tick();
        check("ovr_dout", dout, 4'h5);
        check("ovr_valid", dout_valid, 1);
        check("ovr_flag", overrun, 1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("ovr_valid_drop", dout_valid, 0);
        check("ovr_flag_sticky", overrun, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        // Consume and complete on the same edge
        exp_q.push_back(4'h6);
        exp_q.push_back(4'hF);
        send_word(4'h6, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        dout_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        check("same_edge_valid", dout_valid, 1);
        check("same_edge_dout", dout, 4'hF);
        check("same_edge_overrun", overrun, 0);
        tick();
        check("same_edge_drain", dout_valid, 0);

        // Resync with err_clr on the same edge: set must win
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        check("resync_no_flag", frame_err, 0);
        exp_q.push_back(4'h7);
        err_clr = 1'b1;
        send_bit(1'b1, 1'b1);
        err_clr = 1'b0;
        check("resync_flag", frame_err, 1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("resync_no_early", dout_valid, 0);
        send_bit(1'b0, 1'b0);
        check("resync_dout", dout, 4'h7);
        check("resync_valid", dout_valid, 1);
        tick();

        // Reset mid-word, then idle non-start bits ignored, then B
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", dout_valid, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_dout", dout, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("idle_ignore", dout_valid, 0);
        exp_q.push_back(4'hB);
        send_word(4'hB, 1'b0);
        check("midrst_word", dout, 4'hB);
        check("midrst_word_valid", dout_valid, 1);
        tick();
        tick();
        check("final_flags", {overrun, frame_err}, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sipo_deser
